// File: rtl/uart_pkg.sv
// Shared definitions for the UART frame parser:
// FSM state encoding, error codes and default header bytes.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HDR1    = 3'd1,
        CMD     = 3'd2,
        LEN     = 3'd3,
        PAYLOAD = 3'd4,
        CSUM    = 3'd5
    } state_t;

    localparam logic [1:0] ERR_LEN  = 2'd1;
    localparam logic [1:0] ERR_CSUM = 2'd2;
    localparam logic [1:0] ERR_TOUT = 2'd3;

    localparam logic [7:0] HEAD0_DEF = 8'h55;
    localparam logic [7:0] HEAD1_DEF = 8'hAA;

endpackage

// File: rtl/uart_byte_timeout.sv
// Inter-byte watchdog: counts idle cycles while enabled.
// Ports: sclk, s_rst, clr (zero the count), en (count), tc (terminal count).
module uart_byte_timeout #(
    parameter int TIMEOUT_CYC = 52080
) (
    input  logic sclk,
    input  logic s_rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);

    logic [W-1:0] cnt;

    // Holds at the terminal value; the parser leaves the busy
    // state on tc, which clears the count the following cycle.
    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && cnt != LAST) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = en && (cnt == LAST);

endmodule

// File: rtl/uart_frame_parser.sv
// Frame decoder on a UART byte stream: header hunt, cmd/len/payload, checksum.
// Ports: sclk, s_rst, rx_data/po_flag in; pay_*, frame_*, err_code, busy out.
module uart_frame_parser
    import uart_pkg::*;
#(
    parameter logic [7:0] HEAD0       = HEAD0_DEF,
    parameter logic [7:0] HEAD1       = HEAD1_DEF,
    parameter int         MAX_LEN     = 16,
    parameter int         TIMEOUT_CYC = 52080
) (
    input  logic       sclk,
    input  logic       s_rst,
    input  logic [7:0] rx_data,
    input  logic       po_flag,
    output logic [7:0] pay_data,
    output logic [7:0] pay_addr,
    output logic       pay_wr,
    output logic [7:0] frame_cmd,
    output logic [7:0] frame_len,
    output logic       frame_done,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       busy
);

    localparam logic [7:0] MAX_B = 8'(MAX_LEN);

    state_t     state_q, state_d;
    logic [7:0] cmd_q, cmd_d;
    logic [7:0] len_q, len_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] sum_q, sum_d;
    logic [7:0] pay_data_d, pay_addr_d;
    logic [7:0] frame_cmd_d, frame_len_d;
    logic [1:0] err_code_d;
    logic       pay_wr_d, done_d, err_d;
    logic       tout;

    uart_byte_timeout #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_tout (
        .sclk (sclk),
        .s_rst(s_rst),
        .clr  (po_flag || state_q == IDLE),
        .en   (state_q != IDLE),
        .tc   (tout)
    );

    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            state_q    <= IDLE;
            cmd_q      <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            sum_q      <= '0;
            pay_data   <= '0;
            pay_addr   <= '0;
            pay_wr     <= 1'b0;
            frame_cmd  <= '0;
            frame_len  <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            err_code   <= '0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            sum_q      <= sum_d;
            pay_data   <= pay_data_d;
            pay_addr   <= pay_addr_d;
            pay_wr     <= pay_wr_d;
            frame_cmd  <= frame_cmd_d;
            frame_len  <= frame_len_d;
            frame_done <= done_d;
            frame_err  <= err_d;
            err_code   <= err_code_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        len_d       = len_q;
        idx_d       = idx_q;
        sum_d       = sum_q;
        pay_data_d  = pay_data;
        pay_addr_d  = pay_addr;
        pay_wr_d    = 1'b0;
        frame_cmd_d = frame_cmd;
        frame_len_d = frame_len;
        done_d      = 1'b0;
        err_d       = 1'b0;
        err_code_d  = err_code;

        // A byte arriving on the terminal cycle takes priority.
        if (po_flag) begin
            unique case (state_q)
                IDLE: begin
                    if (rx_data == HEAD0) state_d = HDR1;
                end
                HDR1: begin
                    if (rx_data == HEAD1)      state_d = CMD;
                    else if (rx_data != HEAD0) state_d = IDLE;
                end
                CMD: begin
                    cmd_d   = rx_data;
                    sum_d   = rx_data;
                    state_d = LEN;
                end
                LEN: begin
                    if (rx_data > MAX_B) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_LEN;
                        state_d    = IDLE;
                    end else begin
                        len_d   = rx_data;
                        idx_d   = '0;
                        sum_d   = sum_q + rx_data;
                        state_d = (rx_data == 8'd0) ? CSUM : PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    pay_wr_d   = 1'b1;
                    pay_data_d = rx_data;
                    pay_addr_d = idx_q;
                    sum_d      = sum_q + rx_data;
                    idx_d      = idx_q + 8'd1;
                    if (idx_q == len_q - 8'd1) state_d = CSUM;
                end
                CSUM: begin
                    if (rx_data == sum_q) begin
                        done_d      = 1'b1;
                        frame_cmd_d = cmd_q;
                        frame_len_d = len_q;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = ERR_CSUM;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end else if (tout) begin
            err_d      = 1'b1;
            err_code_d = ERR_TOUT;
            state_d    = IDLE;
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_frame_parser.sv
// Self-checking bench for uart_frame_parser: frame-level model
// compared every cycle, plus literal expectations per scenario.
module tb_uart_frame_parser;

    localparam int MAXL = 16;
    localparam int TOC  = 100;

    typedef logic [7:0] bq_t[$];

    logic       sclk = 1'b0;
    logic       s_rst = 1'b1;
    logic       po_flag = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic [7:0] pay_data, pay_addr, frame_cmd, frame_len;
    logic       pay_wr, frame_done, frame_err, busy;
    logic [1:0] err_code;

    always #5 sclk = ~sclk;

    uart_frame_parser #(
        .MAX_LEN    (MAXL),
        .TIMEOUT_CYC(TOC)
    ) dut (
        .sclk      (sclk),
        .s_rst     (s_rst),
        .rx_data   (rx_data),
        .po_flag   (po_flag),
        .pay_data  (pay_data),
        .pay_addr  (pay_addr),
        .pay_wr    (pay_wr),
        .frame_cmd (frame_cmd),
        .frame_len (frame_len),
        .frame_done(frame_done),
        .frame_err (frame_err),
        .err_code  (err_code),
        .busy      (busy)
    );

    int tests = 0;
    int fails = 0;
    int n_wr = 0, n_done = 0, n_err = 0;
    logic [15:0] wr_log[$];

    // Frame-level model: hdr = header bytes matched (0..2),
    // fb = frame bytes collected after the header.
    int         hdr = 0;
    int         quiet = 0;
    logic [7:0] fb[$];
    logic       e_wr = 0, e_done = 0, e_err = 0, e_busy = 0;
    logic [7:0] e_data = 0, e_addr = 0, e_cmd = 0, e_len = 0;
    logic [1:0] e_code = 0;

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        logic [7:0] s;
        int         l;
        if (hdr == 0) begin
            if (b == 8'h55) hdr = 1;
        end else if (hdr == 1) begin
            if (b == 8'hAA) begin
                hdr = 2;
                fb.delete();
            end else if (b != 8'h55) begin
                hdr = 0;
            end
        end else if (fb.size() == 0) begin
            fb.push_back(b);
        end else if (fb.size() == 1) begin
            if (int'(b) > MAXL) begin
                e_err = 1; e_code = 2'd1; hdr = 0;
            end else begin
                fb.push_back(b);
            end
        end else begin
            l = int'(fb[1]);
            if (fb.size() < 2 + l) begin
                e_wr = 1;
                e_data = b;
                e_addr = 8'(fb.size() - 2);
                fb.push_back(b);
            end else begin
                s = 8'h00;
                foreach (fb[i]) s = s + fb[i];
                if (b == s) begin
                    e_done = 1; e_cmd = fb[0]; e_len = fb[1];
                end else begin
                    e_err = 1; e_code = 2'd2;
                end
                hdr = 0;
            end
        end
    endtask

    // Compare process: check this cycle, then advance the model
    // with the inputs the next rising edge will sample.
    initial forever begin
        @(negedge sclk);
        if (s_rst) begin
            hdr = 0; quiet = 0; fb.delete();
            e_wr = 0; e_done = 0; e_err = 0; e_busy = 0;
            e_data = 0; e_addr = 0; e_cmd = 0; e_len = 0; e_code = 0;
        end
        chk("pay_wr", 16'(pay_wr), 16'(e_wr));
        if (e_wr) begin
            chk("pay_data", 16'(pay_data), 16'(e_data));
            chk("pay_addr", 16'(pay_addr), 16'(e_addr));
        end
        chk("frame_done", 16'(frame_done), 16'(e_done));
        chk("frame_err", 16'(frame_err), 16'(e_err));
        chk("err_code", 16'(err_code), 16'(e_code));
        chk("frame_cmd", 16'(frame_cmd), 16'(e_cmd));
        chk("frame_len", 16'(frame_len), 16'(e_len));
        chk("busy", 16'(busy), 16'(e_busy));
        if (pay_wr) begin
            n_wr++;
            wr_log.push_back({pay_addr, pay_data});
        end
        if (frame_done) n_done++;
        if (frame_err) n_err++;
        if (!s_rst) begin
            e_wr = 0; e_done = 0; e_err = 0;
            if (po_flag) begin
                quiet = 0;
                model_byte(rx_data);
            end else if (hdr != 0) begin
                quiet++;
                if (quiet >= TOC) begin
                    e_err = 1; e_code = 2'd3; hdr = 0;
                end
            end
            e_busy = (hdr != 0);
        end
    end

    task automatic send(input logic [7:0] b);
        @(posedge sclk);
        #2;
        rx_data = b;
        po_flag = 1'b1;
        @(posedge sclk);
        #2;
        po_flag = 1'b0;
    endtask

    task automatic send_all(input bq_t q);
        foreach (q[i]) send(q[i]);
    endtask

    task automatic settle();
        repeat (2) @(negedge sclk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t q;
        int  d0, e0, w0, cyc;
        logic seen;

        repeat (3) @(posedge sclk);
        #2 s_rst = 1'b0;
        @(negedge sclk);
        #1;
        chk("rst_busy", 16'(busy), 16'h0);
        chk("rst_cmd", 16'(frame_cmd), 16'h0);
        chk("rst_code", 16'(err_code), 16'h0);

        // Good frame
        d0 = n_done; e0 = n_err; w0 = n_wr; wr_log.delete();
        q = {8'h55, 8'hAA, 8'h01, 8'h02, 8'h10, 8'h20, 8'h33};
        send_all(q);
        settle();
        chk("good_nwr", 16'(n_wr - w0), 16'd2);
        chk("good_wr0", wr_log[0], 16'h0010);
        chk("good_wr1", wr_log[1], 16'h0120);
        chk("good_done", 16'(n_done - d0), 16'd1);
        chk("good_noerr", 16'(n_err - e0), 16'd0);
        chk("good_cmd", 16'(frame_cmd), 16'h01);
        chk("good_len", 16'(frame_len), 16'h02);

        // Bad checksum
        e0 = n_err; w0 = n_wr;
        q = {8'h55, 8'hAA, 8'h01, 8'h02, 8'h10, 8'h20, 8'h34};
        send_all(q);
        settle();
        chk("csum_nwr", 16'(n_wr - w0), 16'd2);
        chk("csum_err", 16'(n_err - e0), 16'd1);
        chk("csum_code", 16'(err_code), 16'd2);
        chk("csum_cmd_held", 16'(frame_cmd), 16'h01);
        chk("csum_len_held", 16'(frame_len), 16'h02);

        // Oversize length
        e0 = n_err;
        q = {8'h55, 8'hAA, 8'h05, 8'h11};
        send_all(q);
        settle();
        chk("len_err", 16'(n_err - e0), 16'd1);
        chk("len_code", 16'(err_code), 16'd1);
        chk("len_busy", 16'(busy), 16'd0);

        // Zero length with resync
        d0 = n_done; w0 = n_wr;
        q = {8'h00, 8'h55, 8'h55, 8'hAA, 8'h07, 8'h00, 8'h07};
        send_all(q);
        settle();
        chk("zero_nwr", 16'(n_wr - w0), 16'd0);
        chk("zero_done", 16'(n_done - d0), 16'd1);
        chk("zero_cmd", 16'(frame_cmd), 16'h07);
        chk("zero_len", 16'(frame_len), 16'h00);

        // Timeout latency
        q = {8'h55, 8'hAA, 8'h01};
        send_all(q);
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 200) begin
            @(posedge sclk);
            #1;
            cyc++;
            if (frame_err) seen = 1'b1;
        end
        chk("tout_latency", 16'(cyc), 16'd100);
        chk("tout_code", 16'(err_code), 16'd3);
        settle();

        // Byte on the terminal cycle beats the timeout
        d0 = n_done; e0 = n_err;
        q = {8'h55, 8'hAA, 8'h01};
        send_all(q);
        repeat (98) @(posedge sclk);
        send(8'h02);
        q = {8'h10, 8'h20, 8'h33};
        send_all(q);
        settle();
        chk("term_noerr", 16'(n_err - e0), 16'd0);
        chk("term_done", 16'(n_done - d0), 16'd1);

        // Reset mid-payload
        q = {8'h55, 8'hAA, 8'h01, 8'h04, 8'h10};
        send_all(q);
        @(posedge sclk);
        #2 s_rst = 1'b1;
        #1;
        chk("mrst_wr", 16'(pay_wr), 16'd0);
        chk("mrst_data", 16'(pay_data), 16'd0);
        chk("mrst_addr", 16'(pay_addr), 16'd0);
        chk("mrst_cmd", 16'(frame_cmd), 16'd0);
        chk("mrst_len", 16'(frame_len), 16'd0);
        chk("mrst_code", 16'(err_code), 16'd0);
        chk("mrst_busy", 16'(busy), 16'd0);
        @(posedge sclk);
        #2 s_rst = 1'b0;
        d0 = n_done; e0 = n_err; wr_log.delete();
        q = {8'h55, 8'hAA, 8'h03, 8'h01, 8'h7F, 8'h83};
        send_all(q);
        settle();
        chk("post_rst_done", 16'(n_done - d0), 16'd1);
        chk("post_rst_noerr", 16'(n_err - e0), 16'd0);
        chk("post_rst_wr", wr_log[0], 16'h007F);
        chk("post_rst_cmd", 16'(frame_cmd), 16'h03);
        chk("post_rst_len", 16'(frame_len), 16'h01);

        // Back-to-back frames
        d0 = n_done;
        q = {8'h55, 8'hAA, 8'h02, 8'h01, 8'h05, 8'h08,
             8'h55, 8'hAA, 8'h04, 8'h00, 8'h04};
        send_all(q);
        settle();
        chk("b2b_done", 16'(n_done - d0), 16'd2);
        chk("b2b_cmd", 16'(frame_cmd), 16'h04);
        chk("b2b_len", 16'(frame_len), 16'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
